data_bus: RTL and testbench

Data-side memory and I/O subsystem for the single-cycle core. It consumes the core's data address, write data and write enable, and returns read data combinationally in the same cycle. It contains a word-addressed data RAM and four memory-mapped registers: an LED latch, a UART transmitter with a busy flag, and a free-running cycle counter. All state changes on the rising edge of `clk`. Reads have no side effects.

---
 rtl/data_bus.sv | 163 ++++++++++++++++
 tb/tb_data_bus.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_bus.sv
// Data-side memory and I/O for the single-cycle core: word RAM plus LED, UART TX,
// UART status and cycle-counter registers, with a combinational read path.
module data_bus #(
    parameter int RAM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

    localparam logic [31:0] LED_ADDR    = 32'h1000_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'h1000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0008;
    localparam logic [31:0] CYCLE_ADDR  = 32'h1000_000C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    logic [31:0]   ramMem [RAM_WORDS];
    logic [31:0]   wordAddr_s;
    logic          isRam_s;
    logic          ramWrite_s;
    logic          ledWrite_s;
    logic          txWrite_s;
    logic          cycleWrite_s;
    logic          busy_s;

    txState_t      txState_r;
    logic [TW-1:0] bitTimer_r;
    logic [2:0]    bitIdx_r;
    logic [7:0]    txShift_r;
    logic          txOut_r;
    logic [7:0]    led_r;
    logic [31:0]   cycleCnt_r;

    assign wordAddr_s   = {addr[31:2], 2'b00};
    assign isRam_s      = (addr[31:12] == 20'd0);
    // Reset blocks every write, including the RAM, which has no reset of its own.
    assign ramWrite_s   = n_reset && we && isRam_s;
    assign ledWrite_s   = n_reset && we && (wordAddr_s == LED_ADDR);
    assign txWrite_s    = n_reset && we && (wordAddr_s == TXDATA_ADDR);
    assign cycleWrite_s = n_reset && we && (wordAddr_s == CYCLE_ADDR);
    assign busy_s       = (txState_r != IDLE);

    assign led     = led_r;
    assign uart_tx = txOut_r;

    // Data RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (ramWrite_s) begin
            ramMem[addr[AW+1:2]] <= wdata;
        end
    end

    // LED latch.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            led_r <= 8'h00;
        end else if (ledWrite_s) begin
            led_r <= wdata[7:0];
        end
    end

    // Free-running cycle counter; a write clears it ahead of the increment.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cycleCnt_r <= 32'd0;
        end else if (cycleWrite_s) begin
            cycleCnt_r <= 32'd0;
        end else begin
            cycleCnt_r <= cycleCnt_r + 32'd1;
        end
    end

    // UART 8N1 transmitter; txOut_r is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            txState_r  <= IDLE;
            bitTimer_r <= '0;
            bitIdx_r   <= 3'd0;
            txShift_r  <= 8'h00;
            txOut_r    <= 1'b1;
        end else begin
            case (txState_r)
                IDLE: begin
                    txOut_r <= 1'b1;
                    if (txWrite_s) begin
                        txState_r  <= START;
                        bitTimer_r <= TIMER_LOAD;
                        txShift_r  <= wdata[7:0];
                        txOut_r    <= 1'b0;
                    end
                end
                START: begin
                    if (bitTimer_r == '0) begin
                        txState_r  <= DATA;
                        bitIdx_r   <= 3'd0;
                        bitTimer_r <= TIMER_LOAD;
                        txOut_r    <= txShift_r[0];
                    end else begin
                        bitTimer_r <= bitTimer_r - TW'(1);
                    end
                end
                DATA: begin
                    if (bitTimer_r == '0) begin
                        bitTimer_r <= TIMER_LOAD;
                        if (bitIdx_r == 3'd7) begin
                            txState_r <= STOP;
                            txOut_r   <= 1'b1;
                        end else begin
                            bitIdx_r <= bitIdx_r + 3'd1;
                            txOut_r  <= txShift_r[bitIdx_r + 3'd1];
                        end
                    end else begin
                        bitTimer_r <= bitTimer_r - TW'(1);
                    end
                end
                STOP: begin
                    if (bitTimer_r == '0) begin
                        txState_r <= IDLE;
                    end else begin
                        bitTimer_r <= bitTimer_r - TW'(1);
                    end
                end
                default: begin
                    txState_r <= IDLE;
                    txOut_r   <= 1'b1;
                end
            endcase
        end
    end

    // Side-effect-free combinational read mux.
    always_comb begin
        rdata = 32'd0;
        if (isRam_s) begin
            rdata = ramMem[addr[AW+1:2]];
        end else begin
            case (wordAddr_s)
                LED_ADDR:    rdata = {24'd0, led_r};
                TXDATA_ADDR: rdata = 32'd0;
                STATUS_ADDR: rdata = {31'd0, busy_s};
                CYCLE_ADDR:  rdata = cycleCnt_r;
                default:     rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus.sv
// Directed self-checking bench for data_bus with a 4-cycle UART bit period.
module tb_data_bus;

    logic        clk;
    logic        n_reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic        uart_tx;

    int total;
    int bad;
    int busyCount;

    data_bus #(
        .RAM_WORDS   (256),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .led    (led),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        checkVal(tag, rdata, exp);
    endtask

    function automatic logic expBit(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return d[slot-1];
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Reset with a pending LED write that must be blocked.
        n_reset = 1'b0;
        we      = 1'b1;
        addr    = 32'h1000_0000;
        wdata   = 32'h0000_00FF;
        repeat (3) step();
        n_reset = 1'b1;
        we      = 1'b0;
        #1;
        checkVal("rst_led", {24'd0, led}, 32'h0000_0000);
        checkVal("rst_tx", {31'd0, uart_tx}, 32'd1);
        readCheck("rst_status", 32'h1000_0008, 32'd0);
        readCheck("rst_cycle", 32'h1000_000C, 32'd0);

        repeat (10) step();
        readCheck("cycle_10", 32'h1000_000C, 32'd10);

        // RAM write, read-back, alias and read-during-write.
        addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF; we = 1'b1;
        step();
        we = 1'b0;
        readCheck("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        wdata = 32'h1234_5678; we = 1'b1;
        readCheck("ram_rdw_old", 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        we = 1'b0;
        readCheck("ram_new", 32'h0000_0010, 32'h1234_5678);

        // MMIO registers and unmapped space.
        addr = 32'h1000_0000; wdata = 32'h0000_01A5; we = 1'b1;
        step();
        we = 1'b0;
        checkVal("led_out", {24'd0, led}, 32'h0000_00A5);
        readCheck("led_rd", 32'h1000_0000, 32'h0000_00A5);
        readCheck("led_rd_lowbits", 32'h1000_0003, 32'h0000_00A5);
        readCheck("unmapped_rd", 32'h1000_0010, 32'd0);
        addr = 32'h2000_0000; wdata = 32'hFFFF_FFFF; we = 1'b1;
        step();
        we = 1'b0;
        checkVal("unmapped_led", {24'd0, led}, 32'h0000_00A5);
        readCheck("unmapped_ram", 32'h0000_0010, 32'h1234_5678);
        readCheck("unmapped_rd2", 32'h2000_0000, 32'd0);

        // Counter clear, then forced wrap.
        addr = 32'h1000_000C; wdata = 32'h0000_1234; we = 1'b1;
        step();
        we = 1'b0;
        readCheck("cycle_clr", 32'h1000_000C, 32'd0);
        step();
        readCheck("cycle_after_clr", 32'h1000_000C, 32'd1);
        force dut.cycleCnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.cycleCnt_r;
        readCheck("cycle_forced", 32'h1000_000C, 32'hFFFF_FFFE);
        step();
        readCheck("cycle_max", 32'h1000_000C, 32'hFFFF_FFFF);
        step();
        readCheck("cycle_wrap", 32'h1000_000C, 32'd0);

        // UART frame of 0x55, sampled at the first cycle of each bit.
        addr = 32'h1000_0004; wdata = 32'h0000_0055; we = 1'b1;
        step();
        we = 1'b0;
        addr = 32'h1000_0008;
        busyCount = 0;
        for (int i = 0; i < 44; i++) begin
            #1;
            busyCount += int'(rdata[0]);
            if (i < 40 && (i % 4) == 0)
                checkVal($sformatf("tx55_bit%0d", i / 4), {31'd0, uart_tx}, {31'd0, expBit(8'h55, i / 4)});
            step();
        end
        checkVal("tx55_busy_cycles", busyCount, 32'd40);
        checkVal("tx55_idle", {31'd0, uart_tx}, 32'd1);

        // Frame of 0xA3 with TX writes dropped mid-frame and in the last stop cycle.
        addr = 32'h1000_0004; wdata = 32'h0000_00A3; we = 1'b1;
        step();
        busyCount = 0;
        for (int i = 0; i < 44; i++) begin
            if (i == 5 || i == 39) begin
                addr = 32'h1000_0004; wdata = 32'h0000_00FF; we = 1'b1;
            end else begin
                addr = 32'h1000_0008; we = 1'b0;
                #1;
                busyCount += int'(rdata[0]);
            end
            if (i < 40 && (i % 4) == 1)
                checkVal($sformatf("txA3_bit%0d", i / 4), {31'd0, uart_tx}, {31'd0, expBit(8'hA3, i / 4)});
            step();
        end
        we = 1'b0;
        checkVal("txA3_busy_cycles", busyCount, 32'd38);
        for (int i = 0; i < 3; i++) begin
            readCheck("drop_status", 32'h1000_0008, 32'd0);
            checkVal("drop_tx_idle", {31'd0, uart_tx}, 32'd1);
            step();
        end

        // Reset in the middle of a frame of 0x00.
        addr = 32'h1000_0004; wdata = 32'h0000_0000; we = 1'b1;
        step();
        we = 1'b0;
        repeat (9) step();
        checkVal("mid_tx_low", {31'd0, uart_tx}, 32'd0);
        readCheck("mid_busy", 32'h1000_0008, 32'd1);
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        checkVal("midrst_tx", {31'd0, uart_tx}, 32'd1);
        readCheck("midrst_busy", 32'h1000_0008, 32'd0);
        readCheck("midrst_led", 32'h1000_0000, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
